mem_wb_skid_register: RTL and testbench

Elastic MEM/WB pipeline register between the Memory stage (load-mux output, ALU result) and the register-file write-back port. Selects the write-back value (load data or ALU result), registers it with the destination register and write enable, and decouples the stages with a valid/ready handshake backed by a two-entry skid buffer. Memory-stage stalls never combinationally reach write-back, and write-back back-pressure never combinationally reaches Memory.

---
 rtl/mips_pipe_pkg.sv | 17 +
 rtl/mem_wb_skid_register_if.sv | 39 +++
 rtl/mem_wb_skid_register_pipe_skid_buf.sv | 101 ++++++++++
 rtl/mem_wb_skid_register.sv | 67 ++++++
 tb/tb_mem_wb_skid_register.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline definitions: default widths, the $0 register index and
// the MEM/WB payload layout carried through the write-back skid register.
package mips_pipe_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_W  = 5;

    localparam logic [DEF_REG_W-1:0] REG_ZERO = '0;

    // "reg" is a keyword, so the destination index field is regAddr
    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic [DEF_REG_W-1:0]  regAddr;
        logic                  wen;
    } mem_wb_payload_t;

endpackage

// File: rtl/mem_wb_skid_register_if.sv
// MEM/WB bundle: Memory-side handshake and operands, write-back-side handshake
// and payload, plus the stall counter. slave = the register, master = its environment.
interface mem_wb_skid_register_if
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W
) ();

    logic              MemValidIn;
    logic              MemReadyOut;
    logic [DATA_W-1:0] LoadDataIn;
    logic [DATA_W-1:0] ALUResultIn;
    logic [REG_W-1:0]  WriteRegIn;
    logic              RegWriteIn;
    logic              MemToRegIn;
    logic              FlushIn;
    logic              WBValidOut;
    logic              WBReadyIn;
    logic [DATA_W-1:0] WBDataOut;
    logic [REG_W-1:0]  WBRegOut;
    logic              WBRegWriteOut;
    logic [31:0]       StallCountOut;

    modport slave (
        input  MemValidIn, LoadDataIn, ALUResultIn, WriteRegIn, RegWriteIn,
               MemToRegIn, FlushIn, WBReadyIn,
        output MemReadyOut, WBValidOut, WBDataOut, WBRegOut, WBRegWriteOut,
               StallCountOut
    );

    modport master (
        output MemValidIn, LoadDataIn, ALUResultIn, WriteRegIn, RegWriteIn,
               MemToRegIn, FlushIn, WBReadyIn,
        input  MemReadyOut, WBValidOut, WBDataOut, WBRegOut, WBRegWriteOut,
               StallCountOut
    );

endinterface

// File: rtl/mem_wb_skid_register_pipe_skid_buf.sv
// Generic two-entry valid/ready skid buffer: main entry drives the outputs,
// skid entry absorbs one extra accept so upReady can be a pure register.
module pipe_skid_buf #(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         flush,
    input  logic         upValid,
    output logic         upReady,
    input  logic [W-1:0] upData,
    output logic         downValid,
    input  logic         downReady,
    output logic [W-1:0] downData
);

    // bit0 = main entry valid, bit1 = skid entry valid
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } skid_state_t;

    skid_state_t  stateReg, stateNext;
    logic         readyReg;
    logic [W-1:0] mainReg, skidReg;
    logic         accept, deliver;
    logic         loadMain, loadSkid, moveSkid;

    assign accept    = upValid && readyReg;
    assign deliver   = (stateReg != EMPTY) && downReady;
    assign upReady   = readyReg;
    assign downValid = (stateReg != EMPTY);
    assign downData  = mainReg;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stateReg <= EMPTY;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        loadMain  = 1'b0;
        loadSkid  = 1'b0;
        moveSkid  = 1'b0;
        case (stateReg)
            EMPTY: begin
                if (accept) begin
                    stateNext = ONE;
                    loadMain  = 1'b1;
                end
            end
            ONE: begin
                if (accept && !deliver) begin
                    stateNext = FULL;
                    loadSkid  = 1'b1;
                end else if (accept) begin
                    loadMain  = 1'b1;
                end else if (deliver) begin
                    stateNext = EMPTY;
                end
            end
            FULL: begin
                if (deliver) begin
                    stateNext = ONE;
                    moveSkid  = 1'b1;
                end
            end
            default: stateNext = EMPTY;
        endcase
        // Flush overrides everything, including an accept in the same cycle
        if (flush) begin
            stateNext = EMPTY;
            loadMain  = 1'b0;
            loadSkid  = 1'b0;
            moveSkid  = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            readyReg <= 1'b1;
            mainReg  <= '0;
            skidReg  <= '0;
        end else begin
            readyReg <= (stateNext != FULL);
            if (loadMain) begin
                mainReg <= upData;
            end else if (moveSkid) begin
                mainReg <= skidReg;
            end
            if (loadSkid) begin
                skidReg <= upData;
            end
        end
    end

endmodule

// File: rtl/mem_wb_skid_register.sv
// Elastic MEM/WB register: write-back select, $0 masking, skid buffering.
// Define MEM_WB_STALL_CNT_EN to enable the saturating back-pressure counter.
module mem_wb_skid_register
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    mem_wb_skid_register_if.slave   bus
);

    localparam logic [REG_W-1:0] REG_ZERO_W = REG_W'(REG_ZERO);

    logic [DATA_W-1:0] selData;
    logic              selWen;
    mem_wb_payload_t   inPayload, outPayload;
    logic              downValid;

    assign selData = bus.MemToRegIn ? bus.LoadDataIn : bus.ALUResultIn;
    assign selWen  = bus.RegWriteIn && (bus.WriteRegIn != REG_ZERO_W);

    always_comb begin
        inPayload         = '0;
        inPayload.data    = selData;
        inPayload.regAddr = bus.WriteRegIn;
        inPayload.wen     = selWen;
    end

    pipe_skid_buf #(
        .W($bits(mem_wb_payload_t))
    ) u_skid (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .flush     (bus.FlushIn),
        .upValid   (bus.MemValidIn),
        .upReady   (bus.MemReadyOut),
        .upData    (inPayload),
        .downValid (downValid),
        .downReady (bus.WBReadyIn),
        .downData  (outPayload)
    );

    assign bus.WBValidOut    = downValid;
    assign bus.WBDataOut     = outPayload.data;
    assign bus.WBRegOut      = outPayload.regAddr;
    assign bus.WBRegWriteOut = outPayload.wen;

`ifdef MEM_WB_STALL_CNT_EN
    logic [31:0] stallCountReg;

    // Survives flush on purpose; only reset clears it
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stallCountReg <= '0;
        end else if (downValid && !bus.WBReadyIn && (stallCountReg != 32'hFFFF_FFFF)) begin
            stallCountReg <= stallCountReg + 32'd1;
        end
    end

    assign bus.StallCountOut = stallCountReg;
`else
    assign bus.StallCountOut = 32'd0;
`endif

endmodule

// File: tb/tb_mem_wb_skid_register.sv
// Directed + random bench for mem_wb_skid_register against a FIFO-queue model.
module tb_mem_wb_skid_register;
    import mips_pipe_pkg::*;

    logic Clk   = 1'b0;
    logic Rst_n = 1'b0;
    always #5 Clk = ~Clk;

    mem_wb_skid_register_if #(.DATA_W(32), .REG_W(5)) bus ();

    mem_wb_skid_register #(.DATA_W(32), .REG_W(5)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    mem_wb_payload_t q[$];
    logic [31:0] stallModel = 32'd0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] expStall();
`ifdef MEM_WB_STALL_CNT_EN
        return stallModel;
`else
        return 32'd0;
`endif
    endfunction

    task automatic checkOutputs(input string phase);
        check({phase, ".valid"}, bus.WBValidOut, (q.size() > 0));
        check({phase, ".ready"}, bus.MemReadyOut, (q.size() < 2));
        check({phase, ".stall"}, bus.StallCountOut, expStall());
        if (q.size() > 0) begin
            check({phase, ".data"}, bus.WBDataOut, q[0].data);
            check({phase, ".reg"}, bus.WBRegOut, q[0].regAddr);
            check({phase, ".wen"}, bus.WBRegWriteOut, q[0].wen);
        end
    endtask

    task automatic checkResetValues(input string phase);
        check({phase, ".valid"}, bus.WBValidOut, 1'b0);
        check({phase, ".ready"}, bus.MemReadyOut, 1'b1);
        check({phase, ".data"}, bus.WBDataOut, 32'd0);
        check({phase, ".reg"}, bus.WBRegOut, 5'd0);
        check({phase, ".wen"}, bus.WBRegWriteOut, 1'b0);
        check({phase, ".stall"}, bus.StallCountOut, 32'd0);
    endtask

    task automatic cycle(input logic mv, input logic [31:0] ld, input logic [31:0] alu,
                         input logic [4:0] wrg, input logic rw, input logic mtr,
                         input logic rdy, input logic fl, input string phase);
        mem_wb_payload_t p;
        bit acc, del;
        bus.MemValidIn  = mv;
        bus.LoadDataIn  = ld;
        bus.ALUResultIn = alu;
        bus.WriteRegIn  = wrg;
        bus.RegWriteIn  = rw;
        bus.MemToRegIn  = mtr;
        bus.WBReadyIn   = rdy;
        bus.FlushIn     = fl;
        p.data    = mtr ? ld : alu;
        p.regAddr = wrg;
        p.wen     = rw && (wrg != 5'd0);
        acc = mv && (q.size() < 2);
        del = (q.size() > 0) && rdy;
        if ((q.size() > 0) && !rdy && (stallModel != 32'hFFFF_FFFF)) stallModel++;
        if (del) $display("%s: deliver data=%h reg=%0d wen=%0b", phase, q[0].data, q[0].regAddr, q[0].wen);
        @(posedge Clk);
        #1;
        if (fl) begin
            q.delete();
        end else begin
            if (del) void'(q.pop_front());
            if (acc) q.push_back(p);
        end
        checkOutputs(phase);
    endtask

    task automatic idle(input logic rdy, input string phase);
        cycle(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, rdy, 1'b0, phase);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.MemValidIn  = 1'b0;
        bus.LoadDataIn  = '0;
        bus.ALUResultIn = '0;
        bus.WriteRegIn  = '0;
        bus.RegWriteIn  = 1'b0;
        bus.MemToRegIn  = 1'b0;
        bus.WBReadyIn   = 1'b0;
        bus.FlushIn     = 1'b0;

        repeat (3) @(posedge Clk);
        #1;
        checkResetValues("reset");
        @(negedge Clk);
        Rst_n = 1'b1;

        // stall counter: one accept, then 5 cycles of back-pressure
        cycle(1'b1, 32'd0, 32'h5, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, "cnt_acc");
        repeat (5) cycle(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, "cnt_hold");
`ifdef MEM_WB_STALL_CNT_EN
        check("stall_count5", bus.StallCountOut, 32'd5);
`else
        check("stall_count_tied", bus.StallCountOut, 32'd0);
`endif
        idle(1'b1, "cnt_drain");

        // streaming, one per cycle
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 32'hFFFF, 32'h11 * (i + 1), 5'(i + 1), 1'b1, 1'b0, 1'b1, 1'b0, "stream");
            check("stream_data", bus.WBDataOut, 32'h11 * (i + 1));
        end
        idle(1'b1, "stream_drain");

        // back-pressure: third entry must wait
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 32'd0, 32'h101 + i, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, "bp_fill");
            if (i == 1) check("bp_ready_low", bus.MemReadyOut, 1'b0);
        end
        check("bp_head", bus.WBDataOut, 32'h101);
        cycle(1'b1, 32'd0, 32'h103, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, "bp_release");
        check("bp_second", bus.WBDataOut, 32'h102);
        cycle(1'b1, 32'd0, 32'h103, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, "bp_release");
        check("bp_third", bus.WBDataOut, 32'h103);
        idle(1'b1, "bp_drain");
        check("bp_empty", bus.WBValidOut, 1'b0);

        // load select
        cycle(1'b1, 32'hDEADBEEF, 32'h4, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, "load_sel");
        check("load_sel_data", bus.WBDataOut, 32'hDEADBEEF);
        check("load_sel_wen", bus.WBRegWriteOut, 1'b1);
        idle(1'b1, "load_drain");

        // $0 masking
        cycle(1'b1, 32'd0, 32'h55, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, "zero_mask");
        check("zero_mask_valid", bus.WBValidOut, 1'b1);
        check("zero_mask_wen", bus.WBRegWriteOut, 1'b0);
        idle(1'b1, "zero_drain");

        // flush while FULL with MemValidIn high
        cycle(1'b1, 32'd0, 32'hA1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, "fl_fill");
        cycle(1'b1, 32'd0, 32'hA2, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, "fl_fill");
        cycle(1'b1, 32'd0, 32'h99, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, "fl_full");
        check("flush_full_valid", bus.WBValidOut, 1'b0);
        check("flush_full_ready", bus.MemReadyOut, 1'b1);
        // flush with a real accept in the same cycle
        cycle(1'b1, 32'd0, 32'hB1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, "fl_one");
        cycle(1'b1, 32'd0, 32'h77, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, "fl_acc");
        check("flush_acc_valid", bus.WBValidOut, 1'b0);
        idle(1'b1, "fl_after");
        idle(1'b1, "fl_after");
        check("flushed_gone", bus.WBValidOut, 1'b0);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            cycle($urandom_range(0, 3) != 0, $urandom, $urandom, 5'($urandom_range(0, 31)),
                  1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 31) == 0, "rand");
        end

        // reset asserted mid-burst
        cycle(1'b1, 32'd0, 32'hC1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, "rst_fill");
        cycle(1'b1, 32'd0, 32'hC2, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, "rst_fill");
        bus.MemValidIn = 1'b0;
        Rst_n = 1'b0;
        #1;
        q.delete();
        stallModel = 32'd0;
        checkResetValues("rst_mid");
        @(negedge Clk);
        Rst_n = 1'b1;
        cycle(1'b1, 32'd0, 32'hD1, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, "post_rst");
        check("post_rst_data", bus.WBDataOut, 32'hD1);
        idle(1'b1, "post_rst_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
